cpu_sequencer: RTL and testbench

Multi-cycle control FSM for the 16-bit simple-architecture CPU. It steps each instruction through fetch, decode, execute, memory and write-back. It gates the static decode-unit control outputs so that register, memory, PC and SP writes happen only in their own phase. It also handles the memory-ready handshake, with a wait-state timeout, and a sticky halt.

---
 rtl/cpu_ctrl_pkg.sv | 33 +++
 rtl/seq_wait_timer.sv | 49 ++++
 rtl/cpu_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the multi-cycle CPU sequencer.
// Holds the phase encoding (also consumed by debug/trace logic), the
// registered decode-flag bundle and a small helper that identifies the
// phases that own the memory bus.
package cpu_ctrl_pkg;

    // Phase encoding. Values are architectural: trace tools decode them.
    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd7;

    // Decode-unit outputs captured in DECODE and held until write-back.
    typedef struct packed {
        logic regWrite;
        logic memWrite;
        logic memRead;
        logic pcLoad;
        logic condTrue;
        logic spInc;
        logic spDec;
        logic spWrite;
        logic halt;
    } decFlags_t;

    // FETCH and MEM are the only phases that drive a memory request.
    function automatic logic isBusPhase(input logic [2:0] st);
        return (st == ST_FETCH) || (st == ST_MEM);
    endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Wait-state timer for the CPU sequencer.
// Counts consecutive cycles a memory request goes unanswered and flags a
// timeout on the cycle the count would reach WAIT_LIMIT.
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous active-high reset
//   countEn_i  a request is pending and memory is not ready this cycle
//   clear_i    restart the count (memory answered or phase changed)
//   timeout_o  this is the WAIT_LIMIT-th unanswered cycle
module seq_wait_timer #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic countEn_i,
    input  logic clear_i,
    output logic timeout_o
);

    localparam logic [7:0] LAST_COUNT = 8'(WAIT_LIMIT - 1);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // Clearing wins over counting so a phase change always starts the
    // next wait window from zero.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (countEn_i) begin
            count_d = count_q + 8'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Fires during the last permitted wait cycle; a ready in that same
    // cycle drops countEn_i and therefore suppresses the timeout.
    assign timeout_o = countEn_i && (count_q == LAST_COUNT);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM for the 16-bit CPU.
// Steps each instruction through FETCH, DECODE, EXEC, MEM and WB, gating
// the static decode outputs so each write happens only in its own phase.
// Handles the memory-ready handshake with a wait-state timeout and a
// sticky halt.
// Ports:
//   clock, reset                  clock and asynchronous active-high reset
//   dec_*                         static decode-unit control outputs
//   cond_true                     branch condition (1 for unconditional)
//   mem_ready                     memory completes the current access
//   resume                        pulse to leave HALT
//   mem_req, mem_we, addr_sel     memory bus control
//   ir_load, pc_inc, pc_load_en   fetch and PC control
//   reg_we, sp_inc_en, sp_dec_en, sp_we   gated write enables
//   phase, halted, bus_error      status
//   instr_count                   retired-instruction counter
module cpu_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             dec_reg_write,
    input  logic             dec_mem_write,
    input  logic             dec_mem_read,
    input  logic             dec_pc_load,
    input  logic             cond_true,
    input  logic             dec_sp_inc,
    input  logic             dec_sp_dec,
    input  logic             dec_sp_write,
    input  logic             dec_halt,
    input  logic             mem_ready,
    input  logic             resume,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_load,
    output logic             pc_inc,
    output logic             pc_load_en,
    output logic             reg_we,
    output logic             sp_inc_en,
    output logic             sp_dec_en,
    output logic             sp_we,
    output logic [2:0]       phase,
    output logic             halted,
    output logic             bus_error,
    output logic [CNT_W-1:0] instr_count
);

    logic [2:0]       state_q;
    logic [2:0]       state_d;
    decFlags_t        decFlags_q;
    decFlags_t        decFlags_d;
    logic             busError_q;
    logic             busError_d;
    logic [CNT_W-1:0] instrCount_q;
    logic [CNT_W-1:0] instrCount_d;
    logic             waitEn;
    logic             waitClear;
    logic             timeout;

    // The timer only runs while a bus phase is stalled and restarts whenever
    // memory answers or the FSM moves on.
    assign waitEn    = isBusPhase(state_q) && !mem_ready;
    assign waitClear = mem_ready || (state_d != state_q);

    seq_wait_timer #(
        .WAIT_LIMIT(WAIT_LIMIT)
    ) u_waitTimer (
        .clock    (clock),
        .reset    (reset),
        .countEn_i(waitEn),
        .clear_i  (waitClear),
        .timeout_o(timeout)
    );

    // Next-state logic. Decode flags are captured once in DECODE so the
    // decode unit may change freely while the instruction completes.
    always_comb begin
        state_d      = state_q;
        decFlags_d   = decFlags_q;
        busError_d   = busError_q;
        instrCount_d = instrCount_q;
        case (state_q)
            ST_FETCH: begin
                if (mem_ready) begin
                    state_d = ST_DECODE;
                end else if (timeout) begin
                    state_d    = ST_HALT;
                    busError_d = 1'b1;
                end
            end
            ST_DECODE: begin
                decFlags_d.regWrite = dec_reg_write;
                decFlags_d.memWrite = dec_mem_write;
                decFlags_d.memRead  = dec_mem_read;
                decFlags_d.pcLoad   = dec_pc_load;
                decFlags_d.condTrue = cond_true;
                decFlags_d.spInc    = dec_sp_inc;
                decFlags_d.spDec    = dec_sp_dec;
                decFlags_d.spWrite  = dec_sp_write;
                decFlags_d.halt     = dec_halt;
                state_d             = ST_EXEC;
            end
            ST_EXEC: begin
                if (decFlags_q.halt) begin
                    state_d = ST_HALT;
                end else if (decFlags_q.memRead || decFlags_q.memWrite) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (mem_ready) begin
                    state_d = ST_WB;
                end else if (timeout) begin
                    state_d    = ST_HALT;
                    busError_d = 1'b1;
                end
            end
            ST_WB: begin
                instrCount_d = instrCount_q + CNT_W'(1);
                state_d      = ST_FETCH;
            end
            ST_HALT: begin
                if (resume && !busError_q) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_FETCH;
            decFlags_q   <= '0;
            busError_q   <= 1'b0;
            instrCount_q <= '0;
        end else begin
            state_q      <= state_d;
            decFlags_q   <= decFlags_d;
            busError_q   <= busError_d;
            instrCount_q <= instrCount_d;
        end
    end

    // Strobe gating. Strobes are masked by reset so a reset during an
    // access drops the bus request without waiting for a clock edge.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        ir_load    = 1'b0;
        pc_inc     = 1'b0;
        pc_load_en = 1'b0;
        reg_we     = 1'b0;
        sp_inc_en  = 1'b0;
        sp_dec_en  = 1'b0;
        sp_we      = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    ir_load = mem_ready;
                    pc_inc  = mem_ready;
                end
                ST_EXEC: begin
                    pc_load_en = !decFlags_q.halt && decFlags_q.pcLoad && decFlags_q.condTrue;
                end
                ST_MEM: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    mem_we   = decFlags_q.memWrite;
                end
                ST_WB: begin
                    reg_we    = decFlags_q.regWrite;
                    sp_inc_en = decFlags_q.spInc;
                    sp_dec_en = decFlags_q.spDec;
                    sp_we     = decFlags_q.spWrite;
                end
                default: begin
                end
            endcase
        end
    end

    assign phase       = state_q;
    assign halted      = (state_q == ST_HALT);
    assign bus_error   = busError_q;
    assign instr_count = instrCount_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer. Each cycle's expected phase,
// strobe set and retired count are pushed to a scoreboard as stimulus is
// driven and popped for comparison at the following falling edge.
module tb_cpu_sequencer;

    localparam int TB_WAIT_LIMIT = 15;
    localparam int TB_CNT_W      = 4;

    localparam logic [2:0] P_FETCH  = 3'd0;
    localparam logic [2:0] P_DECODE = 3'd1;
    localparam logic [2:0] P_EXEC   = 3'd2;
    localparam logic [2:0] P_MEM    = 3'd3;
    localparam logic [2:0] P_WB     = 3'd4;
    localparam logic [2:0] P_HALT   = 3'd7;

    localparam logic [11:0] B_NONE = 12'h000;
    localparam logic [11:0] B_REQ  = 12'h800;
    localparam logic [11:0] B_WE   = 12'h400;
    localparam logic [11:0] B_ADDR = 12'h200;
    localparam logic [11:0] B_IR   = 12'h100;
    localparam logic [11:0] B_PCI  = 12'h080;
    localparam logic [11:0] B_PCL  = 12'h040;
    localparam logic [11:0] B_REG  = 12'h020;
    localparam logic [11:0] B_SPI  = 12'h010;
    localparam logic [11:0] B_SPD  = 12'h008;
    localparam logic [11:0] B_SPW  = 12'h004;
    localparam logic [11:0] B_HALT = 12'h002;
    localparam logic [11:0] B_BERR = 12'h001;

    logic                clock = 1'b0;
    logic                reset;
    logic                dec_reg_write, dec_mem_write, dec_mem_read, dec_pc_load;
    logic                cond_true, dec_sp_inc, dec_sp_dec, dec_sp_write, dec_halt;
    logic                mem_ready, resume;
    logic                mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load_en;
    logic                reg_we, sp_inc_en, sp_dec_en, sp_we;
    logic [2:0]          phase;
    logic                halted, bus_error;
    logic [TB_CNT_W-1:0] instr_count;

    logic [31:0]         observed;
    logic [TB_CNT_W-1:0] expCount;
    logic [31:0]         expQ[$];
    string               tagQ[$];
    int                  checkCount = 0;
    int                  errorCount = 0;

    always #5 clock = ~clock;

    cpu_sequencer #(
        .WAIT_LIMIT(TB_WAIT_LIMIT),
        .CNT_W     (TB_CNT_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .dec_reg_write(dec_reg_write),
        .dec_mem_write(dec_mem_write),
        .dec_mem_read (dec_mem_read),
        .dec_pc_load  (dec_pc_load),
        .cond_true    (cond_true),
        .dec_sp_inc   (dec_sp_inc),
        .dec_sp_dec   (dec_sp_dec),
        .dec_sp_write (dec_sp_write),
        .dec_halt     (dec_halt),
        .mem_ready    (mem_ready),
        .resume       (resume),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .addr_sel     (addr_sel),
        .ir_load      (ir_load),
        .pc_inc       (pc_inc),
        .pc_load_en   (pc_load_en),
        .reg_we       (reg_we),
        .sp_inc_en    (sp_inc_en),
        .sp_dec_en    (sp_dec_en),
        .sp_we        (sp_we),
        .phase        (phase),
        .halted       (halted),
        .bus_error    (bus_error),
        .instr_count  (instr_count)
    );

    // Everything observable packed into one word: phase, twelve strobes/flags, count.
    assign observed = {13'b0, phase, mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load_en,
                       reg_we, sp_inc_en, sp_dec_en, sp_we, halted, bus_error, instr_count};

    function automatic logic [31:0] packExp(input logic [2:0] ph, input logic [11:0] strobes);
        return {13'b0, ph, strobes, expCount};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One cycle: queue the expectation, compare at the falling edge, return just after the next rising edge.
    task automatic expectCycle(input string tag, input logic [2:0] ph, input logic [11:0] strobes);
        string t;
        logic [31:0] e;
        expQ.push_back(packExp(ph, strobes));
        tagQ.push_back(tag);
        @(negedge clock);
        e = expQ.pop_front();
        t = tagQ.pop_front();
        checkOutput(t, observed, e);
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic regW, input logic memW, input logic memR,
                                 input logic pcL, input logic cond, input logic spI,
                                 input logic spD, input logic spW, input logic hlt);
        dec_reg_write = regW;
        dec_mem_write = memW;
        dec_mem_read  = memR;
        dec_pc_load   = pcL;
        cond_true     = cond;
        dec_sp_inc    = spI;
        dec_sp_dec    = spD;
        dec_sp_write  = spW;
        dec_halt      = hlt;
    endtask

    // Drives one full instruction and its expected per-cycle trace. Decode
    // inputs are inverted after DECODE to confirm the sequencer holds its copy.
    task automatic runInstr(input string tag, input logic regW, input logic memW, input logic memR,
                            input logic pcL, input logic cond, input logic spI, input logic spD,
                            input logic spW, input logic hlt, input int fetchWaits, input int memWaits);
        logic [11:0] s;
        applyStimulus(regW, memW, memR, pcL, cond, spI, spD, spW, hlt);
        resume = 1'b0;
        for (int i = 0; i < fetchWaits; i++) begin
            mem_ready = 1'b0;
            expectCycle({tag, "/fetch-wait"}, P_FETCH, B_REQ);
        end
        mem_ready = 1'b1;
        expectCycle({tag, "/fetch"}, P_FETCH, B_REQ | B_IR | B_PCI);
        expectCycle({tag, "/decode"}, P_DECODE, B_NONE);
        applyStimulus(~regW, ~memW, ~memR, ~pcL, ~cond, ~spI, ~spD, ~spW, ~hlt);
        s = (pcL && cond && !hlt) ? B_PCL : B_NONE;
        expectCycle({tag, "/exec"}, P_EXEC, s);
        if (hlt) begin
            mem_ready = 1'b0;
            expectCycle({tag, "/halt"}, P_HALT, B_HALT);
            return;
        end
        if (memR || memW) begin
            s = B_REQ | B_ADDR | (memW ? B_WE : B_NONE);
            for (int i = 0; i < memWaits; i++) begin
                mem_ready = 1'b0;
                expectCycle({tag, "/mem-wait"}, P_MEM, s);
            end
            mem_ready = 1'b1;
            expectCycle({tag, "/mem"}, P_MEM, s);
        end
        s = (regW ? B_REG : B_NONE) | (spI ? B_SPI : B_NONE) |
            (spD ? B_SPD : B_NONE) | (spW ? B_SPW : B_NONE);
        expectCycle({tag, "/wb"}, P_WB, s);
        expCount = expCount + 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b0;
        resume    = 1'b0;
        expCount  = '0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clock);
        #1;
        expectCycle("reset", P_FETCH, B_NONE);
        reset = 1'b0;

        // Basic classes: ALU, store with waits, load, branches, stack ops.
        runInstr("add",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        runInstr("st",       0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2);
        runInstr("ld",       1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        runInstr("br-nt",    0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        runInstr("br-t",     0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        runInstr("push",     0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1);
        runInstr("pop",      1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        runInstr("ldsp",     0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

        // Ready arriving on the last permitted wait cycle must win.
        runInstr("edge-f",   1, 0, 0, 0, 0, 0, 0, 0, 0, TB_WAIT_LIMIT - 1, 0);
        runInstr("edge-m",   1, 0, 1, 0, 0, 0, 0, 0, 0, 0, TB_WAIT_LIMIT - 1);

        // HLT: sits in HALT uncounted until resume.
        runInstr("hlt",      0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0);
        expectCycle("hlt/hold", P_HALT, B_HALT);
        resume = 1'b1;
        expectCycle("hlt/resume", P_HALT, B_HALT);
        resume = 1'b0;
        runInstr("after-hlt", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Fetch timeout: bus error, HALT, resume ignored.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        mem_ready = 1'b0;
        for (int i = 0; i < TB_WAIT_LIMIT; i++) begin
            expectCycle("timeout/wait", P_FETCH, B_REQ);
        end
        expectCycle("timeout/halt", P_HALT, B_HALT | B_BERR);
        resume = 1'b1;
        expectCycle("timeout/resume", P_HALT, B_HALT | B_BERR);
        resume = 1'b0;
        expectCycle("timeout/sticky", P_HALT, B_HALT | B_BERR);

        // Only reset clears the bus error.
        reset    = 1'b1;
        expCount = '0;
        #1;
        checkOutput("reset-clears-error", observed, packExp(P_FETCH, B_NONE));
        @(posedge clock);
        #1;
        reset = 1'b0;
        runInstr("post-err", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset in the middle of a MEM wait drops everything asynchronously.
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
        mem_ready = 1'b1;
        expectCycle("midreset/fetch", P_FETCH, B_REQ | B_IR | B_PCI);
        expectCycle("midreset/decode", P_DECODE, B_NONE);
        expectCycle("midreset/exec", P_EXEC, B_NONE);
        mem_ready = 1'b0;
        expectCycle("midreset/mem-wait", P_MEM, B_REQ | B_ADDR | B_WE);
        #2;
        reset    = 1'b1;
        expCount = '0;
        #1;
        checkOutput("midreset/async", observed, packExp(P_FETCH, B_NONE));
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Random instruction mix; runs past 2^CNT_W retirements to show wrap.
        for (int n = 0; n < 20; n++) begin
            logic [2:0] cls;
            int fw, mw;
            cls = 3'($urandom_range(0, 5));
            fw  = $urandom_range(0, 3);
            mw  = $urandom_range(0, 3);
            case (cls)
                3'd0:    runInstr("rnd-add",  1, 0, 0, 0, 0, 0, 0, 0, 0, fw, mw);
                3'd1:    runInstr("rnd-st",   0, 1, 0, 0, 0, 0, 0, 0, 0, fw, mw);
                3'd2:    runInstr("rnd-ld",   1, 0, 1, 0, 0, 0, 0, 0, 0, fw, mw);
                3'd3:    runInstr("rnd-br",   0, 0, 0, 1, n[0], 0, 0, 0, 0, fw, mw);
                3'd4:    runInstr("rnd-call", 0, 1, 0, 1, 1, 0, 1, 0, 0, fw, mw);
                default: runInstr("rnd-ret",  0, 0, 1, 1, 1, 1, 0, 0, 0, fw, mw);
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
